imem_loader: RTL

Program loader that fills the instruction memory before the datapath starts fetching. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them to consecutive even byte addresses, matching the PC's +2 stride. It holds the datapath in stall until the image is written and its checksum is verified. It sits between the host/boot link and the instruction memory write port, and drives the datapath's PC-hold input.

---
 rtl/imem_loader_if.sv | 13 +
 rtl/imem_loader.sv | 90 +++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream receive handshake plus instruction memory write port
// master: host side, drives rx_data/rx_valid and observes the memory write port
// slave:  loader side, accepts bytes via rx_ready and drives imem_we/imem_addr/imem_wdata
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  modport master(output rx_data, rx_valid, input rx_ready, imem_we, imem_addr, imem_wdata);
  modport slave(input rx_data, rx_valid, output rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed byte stream into instruction memory as big-endian 16-bit words
// clk, rst      : clock and synchronous active-high reset
// i_start       : begins a load from IDLE, DONE or ERR
// ld (slave)    : rx_data/rx_valid/rx_ready byte handshake and imem_we/imem_addr/imem_wdata write port
// o_cpu_hold    : holds the datapath until a load completes with a good checksum
// o_done/o_error: load succeeded / failed (bad checksum or oversize length)
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  imem_loader_if.slave ld,
  output logic         o_cpu_hold,
  output logic         o_done,
  output logic         o_error
);
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;
  state_t      r_state, w_next;
  logic        r_rx_ready, r_we, r_cpu_hold, r_done, r_error;
  logic [15:0] r_addr, r_wdata, r_len, r_cnt;
  logic [7:0]  r_xor;
  logic        w_xfer, w_restart;
  logic [15:0] w_n, w_cnt_inc;
  assign w_xfer    = ld.rx_valid & r_rx_ready;
  assign w_restart = i_start & (r_state == S_IDLE | r_state == S_DONE | r_state == S_ERR);
  // full word count as seen while the low length byte is on the bus
  assign w_n       = {r_len[15:8], ld.rx_data};
  assign w_cnt_inc = r_cnt + 16'd1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: w_next = i_start ? S_LEN_HI : r_state;
      S_LEN_HI:  w_next = w_xfer ? S_LEN_LO : r_state;
      S_LEN_LO:  if (w_xfer) w_next = (w_n > MAX_WORDS) ? S_ERR : (w_n == 16'd0) ? S_CSUM : S_DATA_HI;
      S_DATA_HI: w_next = w_xfer ? S_DATA_LO : r_state;
      S_DATA_LO: w_next = w_xfer ? S_WRITE : r_state;
      S_WRITE:   w_next = (w_cnt_inc == r_len) ? S_CSUM : S_DATA_HI;
      S_CSUM:    if (w_xfer) w_next = (ld.rx_data == r_xor) ? S_DONE : S_ERR;
      default:   w_next = S_IDLE;
    endcase
  end
  // all outputs are registered decodes of the next state so they line up with r_state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= 16'h0000;
      r_len      <= 16'h0000;
      r_cnt      <= 16'h0000;
      r_xor      <= 8'h00;
    end else begin
      r_state    <= w_next;
      r_rx_ready <= w_next inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
      r_we       <= w_next == S_WRITE;
      r_cpu_hold <= w_next != S_DONE;
      r_done     <= w_next == S_DONE;
      r_error    <= w_next == S_ERR;
      if (w_restart) begin
        r_xor  <= 8'h00;
        r_cnt  <= 16'h0000;
        r_addr <= BASE_ADDR;
      end
      if (w_xfer && r_state != S_CSUM) r_xor <= r_xor ^ ld.rx_data;
      if (w_xfer && r_state == S_LEN_HI) r_len[15:8] <= ld.rx_data;
      if (w_xfer && r_state == S_LEN_LO) r_len[7:0] <= ld.rx_data;
      if (w_xfer && r_state == S_DATA_HI) r_wdata[15:8] <= ld.rx_data;
      if (w_xfer && r_state == S_DATA_LO) r_wdata[7:0] <= ld.rx_data;
      if (r_state == S_WRITE) begin
        r_addr <= r_addr + 16'd2;
        r_cnt  <= w_cnt_inc;
      end
    end
  end
  assign ld.rx_ready   = r_rx_ready;
  assign ld.imem_we    = r_we;
  assign ld.imem_addr  = r_addr;
  assign ld.imem_wdata = r_wdata;
  assign o_cpu_hold    = r_cpu_hold;
  assign o_done        = r_done;
  assign o_error       = r_error;
endmodule
